// File: rtl/lvds_rx_pkg.sv
// rtl/lvds_rx_pkg.sv - shared types and defaults for the LVDS receive alignment sequencer
package lvds_rx_pkg;

  localparam int NCH_DEF         = 30;
  localparam int DESER_DEF       = 10;
  localparam logic [DESER_DEF-1:0] TRAIN_WORD_DEF = 10'h3F0;
  localparam int PLL_RST_CYC_DEF = 16;
  localparam int LOCK_TO_DEF     = 4096;
  localparam int SETTLE_CYC_DEF  = 8;
  localparam int MATCH_CNT_DEF   = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PLL_RST   = 4'd1,
    ST_WAIT_LOCK = 4'd2,
    ST_CDA_RST   = 4'd3,
    ST_SETTLE    = 4'd4,
    ST_CHECK     = 4'd5,
    ST_SLIP      = 4'd6,
    ST_NEXT      = 4'd7,
    ST_DONE      = 4'd8,
    ST_FAIL      = 4'd9
  } state_e;

  // A sequence is in progress everywhere except the three resting states.
  function automatic logic st_busy(state_e s);
    return !(s inside {ST_IDLE, ST_DONE, ST_FAIL});
  endfunction

  // States in which losing PLL lock forces an automatic restart.
  function automatic logic st_lock_watched(state_e s);
    return s inside {ST_CDA_RST, ST_SETTLE, ST_CHECK, ST_SLIP, ST_NEXT, ST_DONE};
  endfunction

  // Largest of three cycle counts, used to size the shared timer.
  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lvds_rx_align_ctrl_if.sv
// rtl/lvds_rx_align_ctrl_if.sv - deserializer-side link between the sequencer and the LVDS receiver
interface lvds_rx_align_ctrl_if
  import lvds_rx_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int DESER = DESER_DEF
);

  logic                   I_rx_locked;
  logic [NCH*DESER-1:0]   I_rx_data;
  logic                   O_pll_areset;
  logic [NCH-1:0]         O_rx_cda_reset;
  logic [NCH-1:0]         O_rx_cda;

  // Sequencer side: drives PLL reset and per-lane CDA controls.
  modport master (
    input  I_rx_locked,
    input  I_rx_data,
    output O_pll_areset,
    output O_rx_cda_reset,
    output O_rx_cda
  );

  // Deserializer side: supplies lock and parallel words.
  modport slave (
    output I_rx_locked,
    output I_rx_data,
    input  O_pll_areset,
    input  O_rx_cda_reset,
    input  O_rx_cda
  );

endinterface

// File: rtl/lvds_lane_word_mux.sv
// rtl/lvds_lane_word_mux.sv - registered selection of the word of the lane under test
module lvds_lane_word_mux
  import lvds_rx_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int DESER = DESER_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NCH*DESER-1:0]       data_i,
  input  logic [$clog2(NCH)-1:0]     lane_i,
  output logic [DESER-1:0]           word_o
);

  localparam int LW = $clog2(NCH);

  logic [DESER-1:0] word_d;
  logic [DESER-1:0] word_q;

  // Pick the lane's word out of the flat bus; out-of-range lane yields zero.
  always_comb begin
    word_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (lane_i == LW'(k)) begin
        word_d = data_i[k*DESER +: DESER];
      end
    end
  end

  // One register stage between the wide bus and the compare logic.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/lvds_rx_align_ctrl.sv
// rtl/lvds_rx_align_ctrl.sv - PLL reset, lock wait and per-lane bit-slip alignment sequencer
module lvds_rx_align_ctrl
  import lvds_rx_pkg::*;
#(
  parameter int               NCH         = NCH_DEF,
  parameter int               DESER       = DESER_DEF,
  parameter logic [DESER-1:0] TRAIN_WORD  = TRAIN_WORD_DEF,
  parameter int               PLL_RST_CYC = PLL_RST_CYC_DEF,
  parameter int               LOCK_TO     = LOCK_TO_DEF,
  parameter int               SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int               MATCH_CNT   = MATCH_CNT_DEF
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_start,
  lvds_rx_align_ctrl_if.master lvds,
  output logic                 O_rx_cda_rdy,
  output logic                 O_busy,
  output logic                 O_fail,
  output logic [NCH-1:0]       O_lane_ok
);

  localparam int LW = $clog2(NCH);
  localparam int SW = $clog2(DESER);
  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int TW = $clog2(max3(PLL_RST_CYC, LOCK_TO, SETTLE_CYC) + 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [SW-1:0]   slip_q, slip_d;
  logic [MW-1:0]   match_q, match_d;
  logic            lane_fail_q, lane_fail_d;
  logic [NCH-1:0]  lane_ok_q, lane_ok_d;
  logic            fail_q, fail_d;

  logic            pll_areset_q, pll_areset_d;
  logic [NCH-1:0]  cda_reset_q, cda_reset_d;
  logic [NCH-1:0]  cda_q, cda_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;

  logic [DESER-1:0] lane_word;
  logic [NCH-1:0]   lane_sel;

  lvds_lane_word_mux #(
    .NCH   (NCH),
    .DESER (DESER)
  ) u_word_mux (
    .clk_i   (I_clk),
    .rst_n_i (I_rst_n),
    .data_i  (lvds.I_rx_data),
    .lane_i  (lane_q),
    .word_o  (lane_word)
  );

  // Next state, counters and registered-output decode from the next state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    lane_d      = lane_q;
    slip_d      = slip_q;
    match_d     = match_q;
    lane_fail_d = lane_fail_q;
    lane_ok_d   = lane_ok_q;
    fail_d      = fail_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (I_start) begin
          state_d     = ST_PLL_RST;
          timer_d     = '0;
          lane_d      = '0;
          lane_ok_d   = '0;
          lane_fail_d = 1'b0;
          fail_d      = 1'b0;
        end
      end
      ST_PLL_RST: begin
        if (timer_q == TW'(PLL_RST_CYC - 1)) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lvds.I_rx_locked) begin
          state_d = ST_CDA_RST;
          timer_d = '0;
        end else if (timer_q == TW'(LOCK_TO - 1)) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_CDA_RST: begin
        slip_d  = '0;
        timer_d = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_q == TW'(SETTLE_CYC - 1)) begin
          state_d = ST_CHECK;
          timer_d = '0;
          match_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_CHECK: begin
        // The mux output lags the bus by one cycle; SETTLE covers that lag.
        if (lane_word == TRAIN_WORD) begin
          match_d = match_q + MW'(1);
          if (match_q == MW'(MATCH_CNT - 1)) begin
            lane_ok_d[lane_q] = 1'b1;
            state_d           = ST_NEXT;
          end
        end else begin
          state_d = ST_SLIP;
        end
      end
      ST_SLIP: begin
        if (slip_q == SW'(DESER - 1)) begin
          lane_fail_d = 1'b1;
          state_d     = ST_NEXT;
        end else begin
          slip_d  = slip_q + SW'(1);
          timer_d = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_NEXT: begin
        if (lane_q == LW'(NCH - 1)) begin
          if (lane_fail_q) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          lane_d  = lane_q + LW'(1);
          state_d = ST_CDA_RST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Losing lock after the PLL came up invalidates every lane: start over.
    if (st_lock_watched(state_q) && !lvds.I_rx_locked) begin
      state_d     = ST_PLL_RST;
      timer_d     = '0;
      lane_d      = '0;
      slip_d      = '0;
      match_d     = '0;
      lane_ok_d   = '0;
      lane_fail_d = 1'b0;
      fail_d      = 1'b0;
    end

    lane_sel     = NCH'(1) << lane_d;
    pll_areset_d = (state_d == ST_PLL_RST);
    busy_d       = st_busy(state_d);
    rdy_d        = (state_d == ST_DONE);
    cda_reset_d  = (state_d == ST_CDA_RST) ? lane_sel : '0;
    // Entering SLIP with the last slip position already used means the lane failed: no pulse.
    cda_d        = ((state_d == ST_SLIP) && (slip_d != SW'(DESER - 1))) ? lane_sel : '0;
  end

  // State register, counters and registered outputs; reset clears all outputs at once.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      lane_q       <= '0;
      slip_q       <= '0;
      match_q      <= '0;
      lane_fail_q  <= 1'b0;
      lane_ok_q    <= '0;
      fail_q       <= 1'b0;
      pll_areset_q <= 1'b0;
      cda_reset_q  <= '0;
      cda_q        <= '0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lane_q       <= lane_d;
      slip_q       <= slip_d;
      match_q      <= match_d;
      lane_fail_q  <= lane_fail_d;
      lane_ok_q    <= lane_ok_d;
      fail_q       <= fail_d;
      pll_areset_q <= pll_areset_d;
      cda_reset_q  <= cda_reset_d;
      cda_q        <= cda_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
    end
  end

  assign lvds.O_pll_areset   = pll_areset_q;
  assign lvds.O_rx_cda_reset = cda_reset_q;
  assign lvds.O_rx_cda       = cda_q;
  assign O_rx_cda_rdy        = rdy_q;
  assign O_busy              = busy_q;
  assign O_fail              = fail_q;
  assign O_lane_ok           = lane_ok_q;

endmodule
